fetch_sequencer: RTL and testbench

Instruction-fetch sequencer between the CPU core and the program memory. Owns the program counter, drives the program-memory address, captures each 16-bit instruction word and hands it to the core with a valid/ready handshake. Handles run/step commands from the debug unit, detects HALT (opcode 00000), and applies jumps reported by the core. Sits directly in front of the program memory; it is the memory's only address source.

---
 rtl/fetch_sequencer_pkg.sv | 24 ++
 rtl/fetch_sequencer_pc_counter.sv | 27 ++
 rtl/fetch_sequencer.sv | 108 ++++++++++
 tb/tb_fetch_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared opcode and state definitions for the fetch sequencer
package fetch_sequencer_pkg;

  localparam int OPC_W = 5;
  localparam logic [OPC_W-1:0] OPC_HALT = 5'b00000;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_FETCH = ST_FETCH,
    S_ISSUE = ST_ISSUE,
    S_HALT  = ST_HALT
  } state_t;

  // Opcode occupies the top OPC_W bits of the instruction word
  function automatic int opc_lsb(input int db);
    return db - OPC_W;
  endfunction

endpackage

// File: rtl/fetch_sequencer_pc_counter.sv
// rtl/fetch_sequencer_pc_counter.sv - program counter register with load-over-increment priority
module pc_counter #(
  parameter int AB = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_load,
  input  logic          i_inc,
  input  logic [AB-1:0] i_load_val,
  output logic [AB-1:0] o_pc
);

  logic [AB-1:0] r_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= '0;
    end else if (i_load) begin
      r_pc <= i_load_val;
    end else if (i_inc) begin
      r_pc <= r_pc + AB'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch sequencer: PC, program-memory address, issue handshake
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int AB = 11,
  parameter int DB = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          step,
  output logic [AB-1:0] pm_addr,
  input  logic [DB-1:0] pm_data,
  output logic [DB-1:0] instr,
  output logic          instr_valid,
  input  logic          cpu_ready,
  input  logic          jmp_en,
  input  logic [AB-1:0] jmp_addr,
  output logic [AB-1:0] pc,
  output logic          halted,
  output logic          busy
);

  localparam int OPC_LSB = opc_lsb(DB);

  state_t        r_state, w_state_nxt;
  logic          r_run_mode, w_run_mode_nxt;
  logic          r_halted, w_halted_nxt;
  logic [AB-1:0] r_pm_addr, w_pm_addr_nxt;
  logic [DB-1:0] r_instr;
  logic [AB-1:0] w_pc, w_pc_plus1;
  logic          w_accept, w_is_halt, w_pc_load, w_pc_inc;

  assign w_accept   = (r_state == S_ISSUE) && cpu_ready;
  assign w_is_halt  = (r_instr[DB-1:OPC_LSB] == OPC_HALT);
  assign w_pc_plus1 = w_pc + AB'(1);
  // A HALT word always advances by one; the core's jump request is dropped
  assign w_pc_load  = w_accept && !w_is_halt && jmp_en;
  assign w_pc_inc   = w_accept && !w_pc_load;

  pc_counter #(.AB(AB)) u_pc_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_pc_load),
    .i_inc      (w_pc_inc),
    .i_load_val (jmp_addr),
    .o_pc       (w_pc)
  );

  always_comb begin
    w_state_nxt    = r_state;
    w_run_mode_nxt = r_run_mode;
    w_halted_nxt   = r_halted;
    w_pm_addr_nxt  = r_pm_addr;
    case (r_state)
      S_IDLE, S_HALT: begin
        if (start || step) begin
          w_state_nxt    = S_FETCH;
          w_run_mode_nxt = start;
          w_halted_nxt   = 1'b0;
          w_pm_addr_nxt  = w_pc;
        end
      end
      S_FETCH: w_state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (cpu_ready) begin
          if (w_is_halt) begin
            w_state_nxt  = S_HALT;
            w_halted_nxt = 1'b1;
          end else if (r_run_mode) begin
            // Address the next PC directly so a jump never fetches down the wrong path
            w_state_nxt   = S_FETCH;
            w_pm_addr_nxt = jmp_en ? jmp_addr : w_pc_plus1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_run_mode <= 1'b0;
      r_halted   <= 1'b0;
      r_pm_addr  <= '0;
      r_instr    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_run_mode <= w_run_mode_nxt;
      r_halted   <= w_halted_nxt;
      r_pm_addr  <= w_pm_addr_nxt;
      if (r_state == S_FETCH) begin
        r_instr <= pm_data;
      end
    end
  end

  assign pm_addr     = r_pm_addr;
  assign instr       = r_instr;
  assign instr_valid = (r_state == S_ISSUE);
  assign pc          = w_pc;
  assign halted      = r_halted;
  assign busy        = (r_state == S_FETCH) || (r_state == S_ISSUE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer against a cycle-timing reference model
module tb_fetch_sequencer;

  localparam int AB    = 11;
  localparam int DB    = 16;
  localparam int DEPTH = 1 << AB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          step = 1'b0;
  logic          cpu_ready = 1'b0;
  logic          jmp_en = 1'b0;
  logic [AB-1:0] jmp_addr = '0;
  logic [DB-1:0] pm_data = '0;
  logic [AB-1:0] pm_addr, pc;
  logic [DB-1:0] instr;
  logic          instr_valid, halted, busy;

  logic [DB-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: PC as a plain integer, "waiting" flag, and the cycle index when a word is due
  int cyc = 0;
  int m_valid_at = 0;
  int m_pc = 0;
  bit m_halted = 1'b0;
  bit m_idle = 1'b1;
  bit m_run = 1'b0;

  fetch_sequencer #(.AB(AB), .DB(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .step        (step),
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .instr       (instr),
    .instr_valid (instr_valid),
    .cpu_ready   (cpu_ready),
    .jmp_en      (jmp_en),
    .jmp_addr    (jmp_addr),
    .pc          (pc),
    .halted      (halted),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) pm_data <= mem[pm_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  task automatic tick(input bit s, input bit st, input bit rdy, input bit je, input int ja);
    bit exp_valid;
    @(negedge clk);
    exp_valid = !m_idle && (cyc >= m_valid_at);
    chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
    chk("busy", 32'(busy), 32'(!m_idle));
    chk("halted", 32'(halted), 32'(m_halted));
    chk("pc", 32'(pc), 32'(m_pc));
    if (!m_idle) chk("pm_addr", 32'(pm_addr), 32'(m_pc));
    if (exp_valid) chk("instr", 32'(instr), 32'(mem[m_pc]));
    start     = s;
    step      = st;
    cpu_ready = rdy;
    jmp_en    = je;
    jmp_addr  = AB'(ja);
    if (m_idle && (s || st)) begin
      m_idle     = 1'b0;
      m_run      = s;
      m_halted   = 1'b0;
      m_valid_at = cyc + 2;
    end else if (exp_valid && rdy) begin
      if (mem[m_pc] < 16'h0800) begin
        m_pc     = (m_pc + 1) % DEPTH;
        m_halted = 1'b1;
        m_idle   = 1'b1;
      end else begin
        m_pc = je ? ja : (m_pc + 1) % DEPTH;
        if (m_run) m_valid_at = cyc + 2;
        else m_idle = 1'b1;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_instr_valid", 32'(instr_valid), 32'h0);
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pm_addr", 32'(pm_addr), 32'h0);
    start = 1'b0; step = 1'b0; cpu_ready = 1'b0; jmp_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_pc = 0; m_halted = 1'b0; m_idle = 1'b1; m_run = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'h0801;
    mem[0] = 16'h0000; mem[1] = 16'h0801; mem[2] = 16'h0000;
    mem[3] = 16'h1002; mem[4] = 16'h0000;

    #12;
    chk("init_instr_valid", 32'(instr_valid), 32'h0);
    chk("init_pc", 32'(pc), 32'h0);
    chk("init_busy", 32'(busy), 32'h0);
    chk("init_instr", 32'(instr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous run stops at each HALT word
    tick(1'b1, 1'b0, 1'b1, 1'b0, 0); run(5);
    chk("run1_pc", 32'(pc), 32'd1); chk("run1_halted", 32'(halted), 32'd1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 0); run(6);
    chk("run2_pc", 32'(pc), 32'd3); chk("run2_halted", 32'(halted), 32'd1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 0); run(6);
    chk("run3_pc", 32'(pc), 32'd5); chk("run3_halted", 32'(halted), 32'd1);

    // Single steps
    apply_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b0, 0); run(4);
    chk("step1_pc", 32'(pc), 32'd1);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 0); run(4);
    chk("step2_pc", 32'(pc), 32'd2); chk("step2_halted", 32'(halted), 32'd0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 0); run(4);
    chk("step3_pc", 32'(pc), 32'd3); chk("step3_halted", 32'(halted), 32'd1);

    // Stall on 0x0801, accept with jump to 3, then jump request on a HALT word is ignored
    apply_reset();
    tick(1'b0, 1'b1, 1'b1, 1'b0, 0); run(4);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
    for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 1'b1, 7);
    chk("stall_instr", 32'(instr), 32'h0801);
    chk("stall_pc", 32'(pc), 32'd1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 3); run(2);
    chk("jump_pc", 32'(pc), 32'd3);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("jump_instr", 32'(instr), 32'h1002);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 'h100);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 'h100);
    run(2);
    chk("halt_jmp_ignored_pc", 32'(pc), 32'd5);

    // PC wrap from the top of memory
    mem[5] = 16'h0801; mem[DEPTH-1] = 16'h1002;
    tick(1'b0, 1'b1, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, DEPTH - 1); run(2);
    chk("wrap_top_pc", 32'(pc), 32'h7FF);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 0); run(4);
    chk("wrap_pc", 32'(pc), 32'h0);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 0);
    chk("wrap_fetch_addr", 32'(pm_addr), 32'h0);
    run(4);

    // Reset while a word is waiting to be accepted
    tick(1'b0, 1'b1, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 0);
    apply_reset();
    run(5);
    chk("post_rst_valid", 32'(instr_valid), 32'h0);

    // Randomized program and control traffic
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = DB'($urandom);
      if ($urandom_range(7) == 0) mem[i] = mem[i] & 16'h07FF;
    end
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 750 == 749) apply_reset();
      tick($urandom_range(9) == 0, $urandom_range(9) == 0, $urandom_range(9) < 7,
           $urandom_range(4) == 0, int'($urandom_range(DEPTH - 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
